// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32IM execute stage: ALU op classes, operand
// selects, forwarding selects, branch / M-extension funct3 codes, muldiv FSM.
package riscv_pkg;

    localparam int XLEN = 32;

    // ALU op classes driven by the decoder
    localparam logic [2:0] ALUOP_ADD    = 3'b000;
    localparam logic [2:0] ALUOP_BRANCH = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
    localparam logic [2:0] ALUOP_ITYPE  = 3'b011;
    localparam logic [2:0] ALUOP_PASS   = 3'b100;

    // Operand A select
    localparam logic [1:0] OPA_RS1  = 2'b00;
    localparam logic [1:0] OPA_PC   = 2'b01;
    localparam logic [1:0] OPA_ZERO = 2'b10;

    // Forwarding selects (11 falls back to the ID/EX value)
    localparam logic [1:0] FWD_IDEX = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // M-extension funct3
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // Integer ALU for R/I-type; 'sub' selects SUB on funct3 000, 'arith' selects SRA.
    function automatic logic [XLEN-1:0] alu_func(
        input logic [2:0]      funct3,
        input logic            sub,
        input logic            arith,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] r;
        case (funct3)
            3'b000:  r = sub ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b011:  r = {{(XLEN-1){1'b0}}, (a < b)};
            3'b100:  r = a ^ b;
            3'b101:  r = arith ? XLEN'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// cycle on operand magnitudes, sign fixup and special cases applied in DONE.
module muldiv_iter
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    md_state_e       state_reg, state_next;
    logic [5:0]      count_reg;
    logic [2:0]      op_reg;
    logic [XLEN-1:0] a_reg;      // original dividend, returned as remainder on /0
    logic [XLEN-1:0] mag_b_reg;  // multiplicand / divisor magnitude
    logic [XLEN-1:0] hi_reg;     // product high word / partial remainder
    logic [XLEN-1:0] lo_reg;     // multiplier -> product low word / dividend -> quotient
    logic            neg_a_reg, neg_b_reg, div0_reg, ovf_reg;

    // Operand signedness and magnitudes at start
    logic            a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        a_signed = (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
        b_signed = (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
        neg_a    = a_signed & a[XLEN-1];
        neg_b    = b_signed & b[XLEN-1];
        mag_a    = neg_a ? (~a + 1'b1) : a;
        mag_b    = neg_b ? (~b + 1'b1) : b;
    end

    // One datapath step: shift-add for multiply, restoring subtract for divide
    logic [XLEN:0] mul_sum, div_shift, div_trial;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mag_b_reg} : '0);
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_trial = div_shift - {1'b0, mag_b_reg};
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= MD_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic: BUSY runs exactly XLEN iterations
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MD_IDLE: if (start) state_next = MD_BUSY;
            MD_BUSY: if (count_reg == 6'(XLEN-1)) state_next = MD_DONE;
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // Operand capture on start and iterative datapath while busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            mag_b_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            neg_a_reg <= 1'b0;
            neg_b_reg <= 1'b0;
            div0_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (state_reg == MD_IDLE && start) begin
            count_reg <= '0;
            op_reg    <= op;
            a_reg     <= a;
            mag_b_reg <= mag_b;
            hi_reg    <= '0;
            lo_reg    <= mag_a;
            neg_a_reg <= neg_a;
            neg_b_reg <= neg_b;
            div0_reg  <= (b == '0);
            ovf_reg   <= (op == F3_DIV || op == F3_REM) &&
                         (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        end else if (state_reg == MD_BUSY) begin
            count_reg <= count_reg + 6'd1;
            if (op_reg[2]) begin
                hi_reg <= div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
                lo_reg <= {lo_reg[XLEN-2:0], ~div_trial[XLEN]};
            end else begin
                hi_reg <= mul_sum[XLEN:1];
                lo_reg <= {mul_sum[0], lo_reg[XLEN-1:1]};
            end
        end
    end

    // Outputs: stall while starting or iterating; signed result in DONE
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quot_s, rem_s;

    always_comb begin
        busy   = (state_reg == MD_BUSY) || (state_reg == MD_IDLE && start);
        done   = (state_reg == MD_DONE);
        prod   = {hi_reg, lo_reg};
        prod_s = (neg_a_reg ^ neg_b_reg) ? (~prod + 1'b1) : prod;
        quot_s = (neg_a_reg ^ neg_b_reg) ? (~lo_reg + 1'b1) : lo_reg;
        rem_s  = neg_a_reg ? (~hi_reg + 1'b1) : hi_reg;
        result = '0;
        if (done) begin
            case (op_reg)
                F3_MUL:    result = prod_s[XLEN-1:0];
                F3_MULH,
                F3_MULHSU,
                F3_MULHU:  result = prod_s[2*XLEN-1:XLEN];
                F3_DIV:    result = div0_reg ? '1 : (ovf_reg ? {1'b1, {(XLEN-1){1'b0}}} : quot_s);
                F3_DIVU:   result = div0_reg ? '1 : lo_reg;
                F3_REM:    result = div0_reg ? a_reg : (ovf_reg ? '0 : rem_s);
                default:   result = div0_reg ? a_reg : hi_reg;
            endcase
        end
    end

endmodule

// File: rtl/etapa_ex.sv
// Execute stage of the RV32IM pipeline: forwarding muxes, ALU, branch/jump
// resolution and the iterative M-extension unit with its pipeline stall.
module etapa_ex
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_ex,
    input  logic [2:0]      ALUOp_ex,
    input  logic            ALUSrc_ex,
    input  logic [1:0]      AuipcLui_ex,
    input  logic            Branch_ex,
    input  logic            Jal_ex,
    input  logic            Jalr_ex,
    input  logic            MulDiv_ex,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [XLEN-1:0] read_data_1_ex,
    input  logic [XLEN-1:0] read_data_2_ex,
    input  logic [XLEN-1:0] imm_ex,
    input  logic [3:0]      instr_3014_ex,
    input  logic [1:0]      ForwardA,
    input  logic [1:0]      ForwardB,
    input  logic [XLEN-1:0] alu_result_mem,
    input  logic [XLEN-1:0] write_data_wb,
    output logic [XLEN-1:0] alu_result_ex,
    output logic [XLEN-1:0] store_data_ex,
    output logic            branch_taken_ex,
    output logic [XLEN-1:0] branch_target_ex,
    output logic            stall_ex
);

    logic [2:0]      funct3;
    logic            bit30;
    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_out;
    logic            cond;
    logic            md_busy, md_done;
    logic [XLEN-1:0] md_result;

    assign funct3 = instr_3014_ex[2:0];
    assign bit30  = instr_3014_ex[3];

    // Forwarding muxes for rs1/rs2
    always_comb begin
        case (ForwardA)
            FWD_MEM: fwd_a = alu_result_mem;
            FWD_WB:  fwd_a = write_data_wb;
            default: fwd_a = read_data_1_ex;
        endcase
        case (ForwardB)
            FWD_MEM: fwd_b = alu_result_mem;
            FWD_WB:  fwd_b = write_data_wb;
            default: fwd_b = read_data_2_ex;
        endcase
    end

    // ALU operand selection
    always_comb begin
        case (AuipcLui_ex)
            OPA_PC:   op_a = pc_ex;
            OPA_ZERO: op_a = '0;
            default:  op_a = fwd_a;
        endcase
        op_b = ALUSrc_ex ? imm_ex : fwd_b;
    end

    // ALU by op class; immediate ops only honour bit30 for SRAI
    always_comb begin
        case (ALUOp_ex)
            ALUOP_ADD,
            ALUOP_PASS:   alu_out = op_a + op_b;
            ALUOP_BRANCH: alu_out = op_a - op_b;
            ALUOP_RTYPE:  alu_out = alu_func(funct3, bit30, bit30, op_a, op_b);
            ALUOP_ITYPE:  alu_out = alu_func(funct3, 1'b0, bit30, op_a, op_b);
            default:      alu_out = '0;
        endcase
    end

    // Branch condition on the forwarded register values
    always_comb begin
        case (funct3)
            F3_BEQ:  cond = (fwd_a == fwd_b);
            F3_BNE:  cond = (fwd_a != fwd_b);
            F3_BLT:  cond = ($signed(fwd_a) < $signed(fwd_b));
            F3_BGE:  cond = ($signed(fwd_a) >= $signed(fwd_b));
            F3_BLTU: cond = (fwd_a < fwd_b);
            F3_BGEU: cond = (fwd_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    muldiv_iter u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (valid_ex & MulDiv_ex),
        .op     (funct3),
        .a      (fwd_a),
        .b      (fwd_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // Stage outputs: result select, redirect and stall
    always_comb begin
        stall_ex      = md_busy;
        store_data_ex = fwd_b;
        if (MulDiv_ex)
            alu_result_ex = md_done ? md_result : '0;
        else if (Jal_ex || Jalr_ex)
            alu_result_ex = pc_ex + 32'd4;
        else
            alu_result_ex = alu_out;
        branch_target_ex = Jalr_ex ? ((fwd_a + imm_ex) & ~32'd1) : (pc_ex + imm_ex);
        branch_taken_ex  = valid_ex & ~stall_ex & (Jal_ex | Jalr_ex | (Branch_ex & cond));
    end

endmodule

// File: tb/tb_etapa_ex.sv
// Directed bench for etapa_ex: ALU, forwarding, branches/jumps, muldiv
// latency, special cases and reset abort of an in-flight divide.
module tb_etapa_ex;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ex;
    logic [2:0]  ALUOp_ex;
    logic        ALUSrc_ex;
    logic [1:0]  AuipcLui_ex;
    logic        Branch_ex, Jal_ex, Jalr_ex, MulDiv_ex;
    logic [31:0] pc_ex, read_data_1_ex, read_data_2_ex, imm_ex;
    logic [3:0]  instr_3014_ex;
    logic [1:0]  ForwardA, ForwardB;
    logic [31:0] alu_result_mem, write_data_wb;
    logic [31:0] alu_result_ex, store_data_ex, branch_target_ex;
    logic        branch_taken_ex, stall_ex;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    etapa_ex dut (
        .clk              (clk),
        .reset            (reset),
        .valid_ex         (valid_ex),
        .ALUOp_ex         (ALUOp_ex),
        .ALUSrc_ex        (ALUSrc_ex),
        .AuipcLui_ex      (AuipcLui_ex),
        .Branch_ex        (Branch_ex),
        .Jal_ex           (Jal_ex),
        .Jalr_ex          (Jalr_ex),
        .MulDiv_ex        (MulDiv_ex),
        .pc_ex            (pc_ex),
        .read_data_1_ex   (read_data_1_ex),
        .read_data_2_ex   (read_data_2_ex),
        .imm_ex           (imm_ex),
        .instr_3014_ex    (instr_3014_ex),
        .ForwardA         (ForwardA),
        .ForwardB         (ForwardB),
        .alu_result_mem   (alu_result_mem),
        .write_data_wb    (write_data_wb),
        .alu_result_ex    (alu_result_ex),
        .store_data_ex    (store_data_ex),
        .branch_taken_ex  (branch_taken_ex),
        .branch_target_ex (branch_target_ex),
        .stall_ex         (stall_ex)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic idle_inputs();
        valid_ex = 1'b0; ALUOp_ex = 3'b000; ALUSrc_ex = 1'b0; AuipcLui_ex = 2'b00;
        Branch_ex = 1'b0; Jal_ex = 1'b0; Jalr_ex = 1'b0; MulDiv_ex = 1'b0;
        pc_ex = '0; read_data_1_ex = '0; read_data_2_ex = '0; imm_ex = '0;
        instr_3014_ex = '0; ForwardA = 2'b00; ForwardB = 2'b00;
        alu_result_mem = '0; write_data_wb = '0;
    endtask

    // Launch one M-extension op, count stall cycles, check the DONE result.
    // Register inputs are clobbered mid-stall: the unit must use captured values.
    task automatic run_md(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        @(negedge clk);
        idle_inputs();
        valid_ex = 1'b1; MulDiv_ex = 1'b1; instr_3014_ex = {1'b0, f3};
        read_data_1_ex = a; read_data_2_ex = b;
        #1;
        n = 0;
        while (stall_ex && n < 100) begin
            n++;
            @(negedge clk);
            if (n == 5) begin
                read_data_1_ex = 32'h1234_5678;
                read_data_2_ex = 32'h0000_0003;
            end
            #1;
        end
        check({tag, "_stall_cycles"}, n, 33);
        check({tag, "_result"}, alu_result_ex, exp);
        valid_ex = 1'b0; MulDiv_ex = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", {31'b0, stall_ex}, 32'd0);
        check("rst_result", alu_result_ex, 32'd0);
        check("rst_taken", {31'b0, branch_taken_ex}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // R-type SUB 5 - 7
        @(negedge clk);
        idle_inputs();
        valid_ex = 1'b1; ALUOp_ex = 3'b010; instr_3014_ex = 4'b1000;
        read_data_1_ex = 32'd5; read_data_2_ex = 32'd7;
        #1;
        check("sub_result", alu_result_ex, 32'hFFFF_FFFE);
        check("sub_stall", {31'b0, stall_ex}, 32'd0);
        check("sub_store", store_data_ex, 32'd7);

        // SRAI keeps bit30; ADDI with bit30 must not subtract
        instr_3014_ex = 4'b1101; ALUOp_ex = 3'b011; ALUSrc_ex = 1'b1;
        read_data_1_ex = 32'h8000_0000; imm_ex = 32'd4;
        #1;
        check("srai_result", alu_result_ex, 32'hF800_0000);
        instr_3014_ex = 4'b1000;
        read_data_1_ex = 32'd10;
        #1;
        check("addi_bit30", alu_result_ex, 32'd14);

        // Forwarding on operand A
        @(negedge clk);
        idle_inputs();
        valid_ex = 1'b1; ALUOp_ex = 3'b000; ALUSrc_ex = 1'b1; imm_ex = 32'd4;
        ForwardA = 2'b10; alu_result_mem = 32'h10; write_data_wb = 32'h20;
        #1;
        check("fwd_mem_add", alu_result_ex, 32'h14);
        ForwardA = 2'b01;
        #1;
        check("fwd_wb_add", alu_result_ex, 32'h24);
        ForwardA = 2'b11; read_data_1_ex = 32'h100;
        #1;
        check("fwd_11_add", alu_result_ex, 32'h104);

        // BLT / BLTU on 0xFFFFFFFF vs 1
        @(negedge clk);
        idle_inputs();
        valid_ex = 1'b1; ALUOp_ex = 3'b001; Branch_ex = 1'b1; instr_3014_ex = 4'b0100;
        read_data_1_ex = 32'hFFFF_FFFF; read_data_2_ex = 32'd1; pc_ex = 32'h100; imm_ex = 32'h20;
        #1;
        check("blt_taken", {31'b0, branch_taken_ex}, 32'd1);
        check("blt_target", branch_target_ex, 32'h120);
        instr_3014_ex = 4'b0110;
        #1;
        check("bltu_taken", {31'b0, branch_taken_ex}, 32'd0);
        valid_ex = 1'b0; instr_3014_ex = 4'b0100;
        #1;
        check("blt_bubble", {31'b0, branch_taken_ex}, 32'd0);

        // JALR with odd target
        @(negedge clk);
        idle_inputs();
        valid_ex = 1'b1; Jalr_ex = 1'b1; pc_ex = 32'h40; read_data_1_ex = 32'h1003; imm_ex = 32'd0;
        #1;
        check("jalr_result", alu_result_ex, 32'h44);
        check("jalr_target", branch_target_ex, 32'h1002);
        check("jalr_taken", {31'b0, branch_taken_ex}, 32'd1);

        // M-extension
        run_md("mulh",   3'b001, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF);
        run_md("mul",    3'b000, 32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFF1);
        run_md("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_md("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md("div0",   3'b100, 32'd7,         32'd0,         32'hFFFF_FFFF);
        run_md("rem0",   3'b110, 32'd7,         32'd0,         32'd7);
        run_md("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_md("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_md("rem_neg",3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run_md("div_neg",3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);

        // Not done yet: MulDiv op must not leak the ALU result
        @(negedge clk);
        idle_inputs();
        MulDiv_ex = 1'b1; read_data_1_ex = 32'd9; read_data_2_ex = 32'd9;
        #1;
        check("md_not_done", alu_result_ex, 32'd0);

        // Reset at BUSY cycle 10 aborts the divide
        @(negedge clk);
        idle_inputs();
        valid_ex = 1'b1; MulDiv_ex = 1'b1; instr_3014_ex = 4'b0101;
        read_data_1_ex = 32'd100; read_data_2_ex = 32'd7;
        repeat (10) @(negedge clk);
        #1;
        check("busy_before_rst", {31'b0, stall_ex}, 32'd1);
        valid_ex = 1'b0; MulDiv_ex = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_abort_stall", {31'b0, stall_ex}, 32'd0);
        check("rst_abort_state", {30'b0, dut.u_muldiv.state_reg}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_md("divu", 3'b101, 32'd100, 32'd7, 32'd14);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
